// File: rtl/alsu_result_buffer_if.sv
// Bundle of capture-side and drain-side signals of the ALSU result buffer.
// master = producer/consumer side, slave = the buffer itself.
interface alsu_result_buffer_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    logic                     in_valid;
    logic [5:0]               in_data;
    logic [15:0]              in_leds;
    logic                     out_valid;
    logic                     out_ready;
    logic [5:0]               out_data;
    logic                     out_err;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [CNT_W-1:0]         res_cnt;
    logic [CNT_W-1:0]         err_cnt;

    modport slave (
        input  in_valid, in_data, in_leds, out_ready,
        output out_valid, out_data, out_err, full, empty, count, overflow, res_cnt, err_cnt
    );

    modport master (
        output in_valid, in_data, in_leds, out_ready,
        input  out_valid, out_data, out_err, full, empty, count, overflow, res_cnt, err_cnt
    );
endinterface

// File: rtl/alsu_result_buffer.sv
// FWFT capture FIFO for ALSU results, tagging entries captured with nonzero leds.
// Optional statistics counters are built only when ALSU_RESULT_STATS_EN is defined.
module alsu_result_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    alsu_result_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [6:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;
    logic          full, empty, pop, push;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign pop   = bus.out_ready & ~empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign push  = bus.in_valid & (~full | pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem_q[wr_ptr_q] <= {|bus.in_leds, bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (bus.in_valid && !push)
                overflow_q <= 1'b1;
        end
    end

`ifdef ALSU_RESULT_STATS_EN
    logic [CNT_W-1:0] res_cnt_q, err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (push) begin
            if (res_cnt_q != '1)
                res_cnt_q <= res_cnt_q + 1'b1;
            if (|bus.in_leds && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.res_cnt = res_cnt_q;
    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.res_cnt = '0;
    assign bus.err_cnt = '0;
`endif

    assign bus.out_valid = ~empty;
    assign bus.out_data  = mem_q[rd_ptr_q][5:0];
    assign bus.out_err   = mem_q[rd_ptr_q][6];
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_alsu_result_buffer.sv
// Directed bench for alsu_result_buffer: driver queues expected {err,data} for
// each push it expects accepted; a negedge monitor pops and compares on every transfer.
module tb_alsu_result_buffer;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alsu_result_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    alsu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] exp_q [$];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; acc says whether this push should be accepted.
    task automatic step(input logic v, input logic [5:0] d, input logic [15:0] l,
                        input logic rdy, input logic acc);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_leds   = l;
        bus.out_ready = rdy;
        if (v && acc)
            exp_q.push_back({|l, d});
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Monitor: every head transfer must match the oldest expected entry.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_pop: got data %0h expected no entry", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_data", int'(bus.out_data), int'(e[5:0]));
                    chk("pop_err", int'(bus.out_err), int'(e[6]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_leds   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_overflow", int'(bus.overflow), 0);

        // Test 1: three pushes, hold, then drain in order
        step(1, 6'h05, 16'h0, 0, 1);
        step(1, 6'h2A, 16'h0, 0, 1);
        step(1, 6'h3F, 16'h0, 0, 1);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t1_count", int'(bus.count), 3);
        chk("t1_head", int'(bus.out_data), 'h05);
        chk("t1_err", int'(bus.out_err), 0);
        repeat (3) step(0, 6'h00, 16'h0, 1, 0);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t1_empty", int'(bus.empty), 1);

        // Test 2: fill, one dropped push
        for (int i = 0; i < 8; i++) step(1, 6'(i), 16'h0, 0, 1);
        step(1, 6'h11, 16'h0, 0, 0);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t2_full", int'(bus.full), 1);
        chk("t2_count", int'(bus.count), 8);
        chk("t2_overflow", int'(bus.overflow), 1);

        // Test 3: push + pop while full
        step(1, 6'h22, 16'h0, 1, 1);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t3_count", int'(bus.count), 8);
        chk("t3_head", int'(bus.out_data), 1);
        repeat (8) step(0, 6'h00, 16'h0, 1, 0);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t3_empty", int'(bus.empty), 1);
        chk("t3_overflow_sticky", int'(bus.overflow), 1);

        // Test 4: error tagging and statistics
        do_reset();
        chk("t4_overflow_clr", int'(bus.overflow), 0);
        step(1, 6'h01, 16'hFFFF, 0, 1);
        step(1, 6'h02, 16'h0000, 0, 1);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t4_head_err", int'(bus.out_err), 1);
        chk("t4_head_data", int'(bus.out_data), 1);
`ifdef ALSU_RESULT_STATS_EN
        chk("t4_res_cnt", int'(bus.res_cnt), 2);
        chk("t4_err_cnt", int'(bus.err_cnt), 1);
`else
        chk("t4_res_cnt", int'(bus.res_cnt), 0);
        chk("t4_err_cnt", int'(bus.err_cnt), 0);
`endif
        step(0, 6'h00, 16'h0, 1, 0);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t4_second_err", int'(bus.out_err), 0);
        chk("t4_second_data", int'(bus.out_data), 2);
        step(0, 6'h00, 16'h0, 1, 0);

        // Test 5: streaming push + pop, pointers wrap
        for (int i = 0; i < 20; i++) begin
            step(1, 6'(6'h30 + i), 16'(i & 1), 1, 1);
            if (i > 0) chk("t5_count", int'(bus.count), 1);
        end
        step(0, 6'h00, 16'h0, 1, 0);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t5_empty", int'(bus.empty), 1);

        // Test 6: reset mid-fill with a push pending
        for (int i = 0; i < 5; i++) step(1, 6'(6'h18 + i), 16'h0, 0, 1);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t6_count_pre", int'(bus.count), 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 6'h3C;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_count", int'(bus.count), 0);
        chk("t6_empty", int'(bus.empty), 1);
        chk("t6_out_valid", int'(bus.out_valid), 0);
        chk("t6_overflow", int'(bus.overflow), 0);
        chk("t6_res_cnt", int'(bus.res_cnt), 0);
        chk("t6_err_cnt", int'(bus.err_cnt), 0);
        step(1, 6'h07, 16'h0, 0, 1);
        step(0, 6'h00, 16'h0, 1, 0);
        step(0, 6'h00, 16'h0, 0, 0);
        chk("t6_post_empty", int'(bus.empty), 1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alsu_result_buffer.md
# alsu_result_buffer

Downstream capture stage for the ALSU. Samples each registered ALSU result (`out`, 6 bits) together with its `leds` status word, tags results produced under an invalid condition, and holds them in a first-word-fall-through FIFO. A consumer drains the FIFO over a valid/ready handshake, so the ALSU never has to stall.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; must be a power of two, at least 2.
- `CNT_W`, default 8: width of the statistics counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  the current `in_data` and `in_leds` are a result to capture.
- `in_data`  in  6  ALSU `out`.
- `in_leds`  in  16  ALSU `leds`. Nonzero marks the result invalid.
- `out_valid`  out  1  head entry available; equals !empty.
- `out_ready`  in  1  consumer accepts the head entry this cycle.
- `out_data`  out  6  head entry data.
- `out_err`  out  1  head entry was captured with `in_leds` != 0.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  log2(DEPTH)+1  current number of entries.
- `overflow`  out  1  sticky flag: a push was dropped.
- `res_cnt`  out  `CNT_W`  accepted pushes; saturating.
- `err_cnt`  out  `CNT_W`  accepted pushes with err = 1; saturating.

## Operation
Storage and pointers:
- Storage is a `DEPTH` x 7-bit array, each entry {err, data}, with err = |in_leds.
- Write and read pointers are log2(DEPTH) bits and wrap modulo `DEPTH`.
- `count` is tracked explicitly.

Push and pop conditions:
- push_req = in_valid.
- pop = out_ready & !empty.
- A push is accepted when !full, or when full and pop is high in the same cycle (simultaneous read frees a slot).

Cycle rules:
- Accepted push: write the entry at wr_ptr and advance wr_ptr.
- Pop: advance rd_ptr.
- `count` changes by +1 on push only, -1 on pop only, and is unchanged when both or neither occur.
- Push while full without pop: the entry is dropped, pointers and count are unchanged, and `overflow` is set to 1. It clears only on `rst`.
- Pop while empty: impossible by definition, so `out_ready` is ignored when `empty` = 1.
- Push while empty with `out_ready` = 1: the push is accepted and no pop occurs.
- `out_data` and `out_err` are driven combinationally from mem[rd_ptr]. Their value is undefined (don't-care) while `empty` = 1, and the bench must not check them then.
- `full` = (count == DEPTH); `empty` = (count == 0).

Reset:
- When `rst` = 1 at an edge: pointers = 0, count = 0, overflow = 0, res_cnt = 0, err_cnt = 0.
- Outputs after reset: `out_valid` = 0, `empty` = 1, `full` = 0.
- Memory contents are not cleared.
- Reset takes priority over a push or pop in the same cycle. A mid-operation reset discards all stored entries.

## Timing
- Push at edge N: the entry is visible on `out_valid`/`out_data` after edge N, i.e. during cycle N+1. Latency is 1 cycle when the FIFO was empty.
- Pop at edge N: the next entry, or `empty` = 1, is presented after edge N.
- `full`, `empty`, `count` and `overflow` are registered or derived from registered state. None depends combinationally on `in_valid` or `out_ready`.
- Sustained throughput is 1 push plus 1 pop per cycle.
- Matches ALSU result timing: connect `in_valid` to the cycle after the ALSU registers its output.

## Configuration
Macro `ALSU_RESULT_STATS_EN`:
- Defined: `res_cnt` and `err_cnt` increment on every accepted push, and `err_cnt` only when err = 1. Both saturate at 2^CNT_W-1. Dropped pushes are not counted.
- Not defined: the counter registers are not built, and `res_cnt` and `err_cnt` are tied to 0. The port list is unchanged.

## Test plan
1. Reset, then 3 pushes of data 6'h05, 6'h2A, 6'h3F with leds = 0, `out_ready` = 0 → count = 3, out_data = 6'h05, out_err = 0; then `out_ready` = 1 for 3 cycles → data 05, 2A, 3F in order, then empty = 1.
2. Push 8 entries (values 0–7) with `out_ready` = 0, then a 9th with data = 6'h11 → full = 1, count = 8, overflow = 1; draining gives 0..7 and never 6'h11.
3. While full, push data = 6'h22 and pop in the same cycle → count stays 8, entry 0 leaves, and 6'h22 is read last.
4. Push data 6'h01 with leds = 16'hFFFF, and data 6'h02 with leds = 0 → out_err = 1 then 0. With the macro defined: res_cnt = 2, err_cnt = 1.
5. Continuous push of an incrementing pattern plus a pop every cycle for 20 cycles → count holds at 1, the output equals the input delayed by 1 cycle, and the pointers wrap with no loss.
6. Fill to 5 entries, assert `rst` for 1 cycle with in_valid = 1 → afterwards count = 0, empty = 1, overflow = 0, counters = 0, and the reset-cycle push is not stored.
